exe_stage: RTL
==============

Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order pipeline. Sits between the decode stage and the memory stage, and feeds the memory stage's EXE_to_MEM_BUS.
- Computes ALU results and issues data-SRAM requests (address, byte write-enables, aligned store data).
- Forms multiplier partial addends; the memory stage finishes the final add.
- Runs an iterative 32-bit divider that stalls the stage until the quotient/remainder is ready.

Parameters:
- DIV_ITERS, 32, number of restoring-division iteration cycles (fixed at 32 for 32-bit operands).

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous, active-low reset.
- ID_to_EXE_BUS  in  `ID_to_EXE_LEN (169)  {pc32, src1 32, src2 32, alu_op12, gr_we1, dest5, mem_en1, mem_we1, load_op5, rfrom_mem1, store_op3(B,H,W), rkd_value32, mul_div_op7}.
- ID_to_EXE_valid  in  1  upstream valid.
- MEM_allowin  in  1  downstream ready.
- EXE_allowin  out  1  stage can accept a new instruction.
- EXE_to_MEM_valid  out  1  downstream valid.
- EXE_to_MEM_BUS  out  `EXE_to_MEM_LEN (253)  {pc32, gr_we1, dest5, exe_result32, data_sum32, mem_en1, load_op5, rfrom_mem1, add1 68, add2 68, cin1, mul_div_op7}.
- EXE_RF_BUS  out  `EXE_RF_LEN (39)  {dest5 masked by gr_we&EXE_valid, rfrom_mem1, div_busy1, exe_result32}, used for forwarding and hazard detection.
- data_sram_en  out  1  SRAM enable.
- data_sram_we  out  4  byte write enables.
- data_sram_addr  out  32  byte address.
- data_sram_wdata  out  32  store data, replicated per lane.

Behaviour:
- Reset (async, resetn=0):
  - EXE_valid=0; bus register=0.
  - Divider FSM to IDLE, counter=0, done=0.
  - All outputs therefore read 0, except EXE_allowin=1.
- Handshake:
  - EXE_ready_go = !is_div | div_done.
  - EXE_allowin = !EXE_valid | (EXE_ready_go & MEM_allowin).
  - EXE_to_MEM_valid = EXE_valid & EXE_ready_go.
  - When EXE_allowin: EXE_valid <= ID_to_EXE_valid.
  - The bus register loads when ID_to_EXE_valid & EXE_allowin.
- is_div = |mul_div_op[3:0]. Encoding: [3] div.w, [2] mod.w, [1] div.wu, [0] mod.wu, [6] mul.w, [5] mulh.w, [4] mulh.wu.
- ALU: the existing alu module is instantiated on src1/src2/alu_op; alu_result is combinational.
- exe_result selection:
  - is_div: quotient for div/divu, remainder for mod/modu.
  - Otherwise: alu_result.
  - data_sum = alu_result.
- Multiplier:
  - A = 34-bit extension of src1; B = 34-bit extension of src2. Sign extension for mul.w/mulh.w, zero extension for mulh.wu.
  - add1 = sext68(A) * B[16:0].
  - add2 = (sext68(A) * sext(B[33:17])) << 17.
  - cin = 0.
  - Required invariant: add1+add2+cin ≡ A*B mod 2^68.
  - For non-mul ops: add1=add2=0.
- Divider FSM (div_iter):
  - IDLE -> RUN when EXE_valid & is_div & !done. Operands are latched as absolute values plus sign flags; counter=0.
  - RUN: one restoring step per cycle. After DIV_ITERS steps -> DONE, with sign fixup applied on exit:
    - quotient is negated if the operand signs differ (signed ops only);
    - remainder takes the dividend's sign.
  - Latency: start in cycle S; done=1 and ready_go=1 in cycle S+33.
  - DONE holds its results until EXE_allowin & EXE_valid is seen (the instruction leaves), then -> IDLE. A stalled MEM keeps the result stable.
  - Divide by zero: quotient=0xFFFFFFFF, remainder=dividend. Same 33-cycle latency.
  - Overflow case: 0x80000000 / -1 gives quotient=0x80000000, remainder=0.
  - div_busy = EXE_valid & is_div & !done.
- Memory request:
  - data_sram_en = EXE_valid & mem_en.
  - data_sram_addr = alu_result.
  - data_sram_we = {4{EXE_valid & mem_we}} & mask:
    - B: 1<<addr[1:0];
    - H: 4'b0011<<addr[1:0] (addr[1] selects the half);
    - W: 4'b1111.
  - data_sram_wdata: B -> {4{rkd[7:0]}}; H -> {2{rkd[15:0]}}; W -> rkd.
  - Repeated writes during a stall are idempotent and permitted.
- A new ID instruction may enter in the same cycle the previous one leaves (back-to-back, no bubble).

Decomposition:
- marco.h gains:
  - ID_to_EXE_LEN, EXE_to_MEM_LEN, EXE_RF_LEN;
  - ST_B/ST_H/ST_W index defines;
  - MUL_DIV op-bit index defines.
- Sub-module div_iter (FSM, 32-bit quotient/remainder registers, 6-bit counter, start/done/busy), resettable by resetn.
- The ALU is the existing alu module, reused unchanged.

Test Plan:
- add: src1=5, src2=7, MEM_allowin=1 -> next cycle EXE_to_MEM_valid=1, exe_result=12; back-to-back instructions show no bubble.
- div.w 7 / -2 issued at cycle S -> EXE_allowin=0 for cycles S..S+32; EXE_to_MEM_valid=1 at S+33 with exe_result=0xFFFFFFFD. mod.w on the same operands gives 1.
- divu 100/0 with MEM_allowin held low for 5 extra cycles -> result 0xFFFFFFFF stays stable; the instruction passes exactly once.
- st.b rkd=0x000000AB, addr=0x1003 -> we=4'b1000, wdata=0xABABABAB, en=1. st.h addr=0x1002 -> we=4'b1100.
- mulh.w src1=0x80000000, src2=2 -> add1+add2+cin, bits [63:32] = 0xFFFFFFFF. mul.w src1=3, src2=-4 -> low 32 bits = 0xFFFFFFF4.
- resetn pulsed low at cycle S+10 of a divide -> outputs zero immediately (async); after release the FSM is IDLE, EXE_allowin=1, and no stale result appears.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared types and constants for the execute stage.
// Bus layouts, store/mul-div op bit indices, ALU op indices, divider states.
package exe_stage_pkg;

  localparam int ID_TO_EXE_LEN  = 169;
  localparam int EXE_TO_MEM_LEN = 253;
  localparam int EXE_RF_LEN     = 39;

  localparam int ST_W = 0;
  localparam int ST_H = 1;
  localparam int ST_B = 2;

  localparam int MD_MODWU = 0;
  localparam int MD_DIVWU = 1;
  localparam int MD_MODW  = 2;
  localparam int MD_DIVW  = 3;
  localparam int MD_MULHWU = 4;
  localparam int MD_MULHW = 5;
  localparam int MD_MULW  = 6;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // Top 5 bits of the decode bus are reserved padding.
  typedef struct packed {
    logic [4:0]  rsvd;
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [11:0] alu_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic        mem_en;
    logic        mem_we;
    logic [4:0]  load_op;
    logic        rfrom_mem;
    logic [2:0]  store_op;
    logic [31:0] rkd;
    logic [6:0]  mul_div_op;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] exe_result;
    logic [31:0] data_sum;
    logic        mem_en;
    logic [4:0]  load_op;
    logic        rfrom_mem;
    logic [67:0] add1;
    logic [67:0] add2;
    logic        cin;
    logic [6:0]  mul_div_op;
  } ex_mem_t;

  typedef struct packed {
    logic [4:0]  dest;
    logic        rfrom_mem;
    logic        div_busy;
    logic [31:0] exe_result;
  } ex_rf_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU, one-hot alu_op.
// Ports: alu_op, alu_src1, alu_src2 in; alu_result out.
module alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic [4:0] sa;
  logic       lt_s;
  logic       lt_u;

  assign sa   = alu_src2[4:0];
  assign lt_s = $signed(alu_src1) < $signed(alu_src2);
  assign lt_u = alu_src1 < alu_src2;

  always_comb begin
    alu_result = '0;
    unique case (1'b1)
      alu_op[ALU_ADD]:  alu_result = alu_src1 + alu_src2;
      alu_op[ALU_SUB]:  alu_result = alu_src1 - alu_src2;
      alu_op[ALU_SLT]:  alu_result = {31'b0, lt_s};
      alu_op[ALU_SLTU]: alu_result = {31'b0, lt_u};
      alu_op[ALU_AND]:  alu_result = alu_src1 & alu_src2;
      alu_op[ALU_NOR]:  alu_result = ~(alu_src1 | alu_src2);
      alu_op[ALU_OR]:   alu_result = alu_src1 | alu_src2;
      alu_op[ALU_XOR]:  alu_result = alu_src1 ^ alu_src2;
      alu_op[ALU_SLL]:  alu_result = alu_src1 << sa;
      alu_op[ALU_SRL]:  alu_result = alu_src1 >> sa;
      alu_op[ALU_SRA]:  alu_result = $signed(alu_src1) >>> sa;
      alu_op[ALU_LUI]:  alu_result = alu_src2;
      default: ;
    endcase
  end

endmodule

// File: rtl/exe_stage_div_iter.sv
// Iterative restoring 32-bit divider, one quotient bit per cycle.
// Ports: start/ack/is_signed/dividend/divisor in; done/quotient/remainder out.
module exe_stage_div_iter
  import exe_stage_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        ack,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic [31:0] d_q, d_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        dz_q, dz_d;
  logic        done_q, done_d;

  logic [32:0] r_sh;
  logic [32:0] diff;
  logic [31:0] q_step;
  logic [31:0] r_step;

  // q_q starts as |dividend| and shifts out MSB-first into the remainder.
  assign r_sh   = {r_q, q_q[31]};
  assign diff   = r_sh - {1'b0, d_q};
  assign q_step = {q_q[30:0], ~diff[32]};
  assign r_step = diff[32] ? r_sh[31:0] : diff[31:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    done_d  = done_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_RUN;
          cnt_d   = '0;
          r_d     = '0;
          q_d     = (is_signed & dividend[31]) ?
                    32'd0 - dividend : dividend;
          d_d     = (is_signed & divisor[31]) ?
                    32'd0 - divisor : divisor;
          negq_d  = is_signed & (dividend[31] ^ divisor[31]);
          negr_d  = is_signed & dividend[31];
          dz_d    = divisor == 32'd0;
        end
      end
      DIV_RUN: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_ITERS - 1)) begin
          state_d = DIV_DONE;
          done_d  = 1'b1;
          q_d = dz_q   ? '1 :
                negq_q ? 32'd0 - q_step : q_step;
          r_d = negr_q ? 32'd0 - r_step : r_step;
        end
      end
      DIV_DONE: begin
        if (ack) begin
          state_d = DIV_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = q_q;
  assign remainder = r_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, SRAM request, multiplier partial sums, divider.
// Ports: decode bus/handshake in; MEM bus, forwarding bus, SRAM request out.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [ID_TO_EXE_LEN-1:0]  ID_to_EXE_BUS,
  input  logic                      ID_to_EXE_valid,
  input  logic                      MEM_allowin,
  output logic                      EXE_allowin,
  output logic                      EXE_to_MEM_valid,
  output logic [EXE_TO_MEM_LEN-1:0] EXE_to_MEM_BUS,
  output logic [EXE_RF_LEN-1:0]     EXE_RF_BUS,
  output logic                      data_sram_en,
  output logic [3:0]                data_sram_we,
  output logic [31:0]               data_sram_addr,
  output logic [31:0]               data_sram_wdata
);

  id_ex_t      id_q, id_d;
  logic        valid_q, valid_d;
  logic [31:0] alu_result;
  logic        is_div, is_mul, mul_sext;
  logic        div_done, div_signed, ready_go;
  logic [31:0] quo, rem, exe_result;
  logic [33:0] a34, b34;
  logic [67:0] a68, b_lo, b_hi;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  ex_mem_t     mem_bus;
  ex_rf_t      rf_bus;
  logic        unused_rsvd;
  logic [6:0]  md;

  assign md = id_q.mul_div_op;
  assign unused_rsvd = ^id_q.rsvd;

  assign is_div = md[MD_DIVW] | md[MD_MODW]
                | md[MD_DIVWU] | md[MD_MODWU];
  assign is_mul = md[MD_MULW] | md[MD_MULHW] | md[MD_MULHWU];
  assign mul_sext = md[MD_MULW] | md[MD_MULHW];
  assign div_signed = md[MD_DIVW] | md[MD_MODW];

  assign ready_go         = ~is_div | div_done;
  assign EXE_allowin      = ~valid_q | (ready_go & MEM_allowin);
  assign EXE_to_MEM_valid = valid_q & ready_go;

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    if (EXE_allowin) valid_d = ID_to_EXE_valid;
    if (ID_to_EXE_valid & EXE_allowin) id_d = id_ex_t'(ID_to_EXE_BUS);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  alu u_alu (
    .alu_op     (id_q.alu_op),
    .alu_src1   (id_q.src1),
    .alu_src2   (id_q.src2),
    .alu_result (alu_result)
  );

  exe_stage_div_iter #(
    .DIV_ITERS (DIV_ITERS)
  ) u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .start     (valid_q & is_div & ~div_done),
    .ack       (EXE_allowin & valid_q),
    .is_signed (div_signed),
    .dividend  (id_q.src1),
    .divisor   (id_q.src2),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  assign exe_result = ~is_div ? alu_result :
                      (md[MD_DIVW] | md[MD_DIVWU]) ? quo : rem;

  // B splits into signed upper 17 bits and unsigned lower 17 bits.
  assign a34  = {{2{mul_sext & id_q.src1[31]}}, id_q.src1};
  assign b34  = {{2{mul_sext & id_q.src2[31]}}, id_q.src2};
  assign a68  = {{34{a34[33]}}, a34};
  assign b_lo = {51'b0, b34[16:0]};
  assign b_hi = {{51{b34[33]}}, b34[33:17]};

  always_comb begin
    st_mask  = '0;
    st_wdata = id_q.rkd;
    unique case (1'b1)
      id_q.store_op[ST_B]: begin
        st_mask  = 4'b0001 << alu_result[1:0];
        st_wdata = {4{id_q.rkd[7:0]}};
      end
      id_q.store_op[ST_H]: begin
        st_mask  = 4'b0011 << alu_result[1:0];
        st_wdata = {2{id_q.rkd[15:0]}};
      end
      id_q.store_op[ST_W]: st_mask = 4'b1111;
      default: ;
    endcase
  end

  assign data_sram_en    = valid_q & id_q.mem_en;
  assign data_sram_addr  = alu_result;
  assign data_sram_we    = {4{valid_q & id_q.mem_we}} & st_mask;
  assign data_sram_wdata = st_wdata;

  always_comb begin
    mem_bus            = '0;
    mem_bus.pc         = id_q.pc;
    mem_bus.gr_we      = id_q.gr_we;
    mem_bus.dest       = id_q.dest;
    mem_bus.exe_result = exe_result;
    mem_bus.data_sum   = alu_result;
    mem_bus.mem_en     = id_q.mem_en;
    mem_bus.load_op    = id_q.load_op;
    mem_bus.rfrom_mem  = id_q.rfrom_mem;
    mem_bus.add1       = is_mul ? a68 * b_lo : '0;
    mem_bus.add2       = is_mul ? (a68 * b_hi) << 17 : '0;
    mem_bus.cin        = 1'b0;
    mem_bus.mul_div_op = md;
  end

  always_comb begin
    rf_bus            = '0;
    rf_bus.dest       = id_q.dest & {5{id_q.gr_we & valid_q}};
    rf_bus.rfrom_mem  = id_q.rfrom_mem;
    rf_bus.div_busy   = valid_q & is_div & ~div_done;
    rf_bus.exe_result = exe_result;
  end

  assign EXE_to_MEM_BUS = mem_bus;
  assign EXE_RF_BUS     = rf_bus;

endmodule
